// File: rtl/sb_pkg.sv
// sb_pkg -- shared definitions for the register scoreboard.
//   NUM_REGS  : number of tracked architectural registers (16)
//   REG_W     : register address width (4)
//   CNT_W_DEF : default width of each in-flight write counter
//   sb_delta_t: per-register change applied at one clock edge
//               (inc = one accepted issue, dec = number of retiring or
//                squashed writes, 0..2)
package sb_pkg;

  localparam int NUM_REGS  = 16;
  localparam int REG_W     = 4;
  localparam int CNT_W_DEF = 2;

  typedef struct packed {
    logic       inc;
    logic [1:0] dec;
  } sb_delta_t;

endpackage

// File: rtl/sb_entry.sv
// sb_entry -- one in-flight write counter of the register scoreboard.
// Ports:
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   i_delta     : change for this edge (+inc, -dec)
//   o_count     : registered counter value
//   o_underflow : sticky flag, set when a decrement would go below zero
// A decrement past zero clamps the counter at zero.
module sb_entry
  import sb_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  sb_delta_t        i_delta,
  output logic [CNT_W-1:0] o_count,
  output logic             o_underflow
);

  logic [CNT_W-1:0] r_count;
  logic             r_underflow;
  logic [CNT_W+1:0] w_up;
  logic [CNT_W+1:0] w_dec;
  logic [CNT_W+1:0] w_diff;
  logic             w_short;

  // Two guard bits so count+inc never wraps before the comparison.
  assign w_up    = {2'b00, r_count} + {{(CNT_W + 1){1'b0}}, i_delta.inc};
  assign w_dec   = {{CNT_W{1'b0}}, i_delta.dec};
  assign w_short = (w_up < w_dec);
  assign w_diff  = w_up - w_dec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_count     <= w_short ? '0 : w_diff[CNT_W-1:0];
      r_underflow <= r_underflow | w_short;
    end
  end

  assign o_count     = r_count;
  assign o_underflow = r_underflow;

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard -- in-flight register write tracker for the decode stage.
// Ports:
//   clk, reset (async, active low)
//   issue_valid / issue_ready : decode presents an instruction; ready is
//                               !hazard, combinational, independent of valid
//   RA1D/use1D, RA2D/use2D    : source registers and whether they are read
//   WA3D/RegWriteD            : destination register of the instruction
//   wb_valid/WA3W             : write-back retires one pending write
//   squash_valid/squash_wa3   : flush cancels one pending write
//   StallD, busy[15:0], pc_write_pending, err_underflow (sticky)
// Handshake: an issue is taken on a rising edge when issue_valid &&
// issue_ready; only taken issues with RegWriteD change a counter.
// Configuration macro SCOREBOARD_PC_TRACK_EN: when defined, register 15
// (PC) is tracked and pc_write_pending = busy[15]; otherwise all events
// to register 15 are dropped and pc_write_pending is 0.
module reg_scoreboard
  import sb_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [REG_W-1:0]    RA1D,
  input  logic [REG_W-1:0]    RA2D,
  input  logic                use1D,
  input  logic                use2D,
  input  logic [REG_W-1:0]    WA3D,
  input  logic                RegWriteD,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    WA3W,
  input  logic                squash_valid,
  input  logic [REG_W-1:0]    squash_wa3,
  output logic                StallD,
  output logic [NUM_REGS-1:0] busy,
  output logic                pc_write_pending,
  output logic                err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]    w_count [NUM_REGS];
  logic [NUM_REGS-1:0] w_underflow;
  sb_delta_t           w_delta [NUM_REGS];
  logic                w_hazard;
  logic                w_accept;

  // Hazard looks only at registered counts: a write-back in this cycle
  // does not release a stalled reader until the next cycle.
  always_comb begin
    w_hazard = (use1D && busy[RA1D]) || (use2D && busy[RA2D]) ||
               (RegWriteD && (w_count[WA3D] == CNT_MAX));
  end

  assign issue_ready = !w_hazard;
  assign StallD      = issue_valid && w_hazard;
  assign w_accept    = issue_valid && !w_hazard && RegWriteD;

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      w_delta[r].inc = w_accept && (WA3D == REG_W'(r));
      w_delta[r].dec = {1'b0, wb_valid && (WA3W == REG_W'(r))} +
                       {1'b0, squash_valid && (squash_wa3 == REG_W'(r))};
    end
`ifndef SCOREBOARD_PC_TRACK_EN
    w_delta[NUM_REGS-1] = '0;
`endif
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
    sb_entry #(.CNT_W(CNT_W)) u_entry (
      .clk         (clk),
      .rst_n       (reset),
      .i_delta     (w_delta[g]),
      .o_count     (w_count[g]),
      .o_underflow (w_underflow[g])
    );
    assign busy[g] = (w_count[g] != '0);
  end

  assign err_underflow = |w_underflow;

`ifdef SCOREBOARD_PC_TRACK_EN
  assign pc_write_pending = busy[NUM_REGS-1];
`else
  assign pc_write_pending = 1'b0;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  localparam int MAXC = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_ready;
  logic [3:0]  RA1D, RA2D, WA3D, WA3W, squash_wa3;
  logic        use1D, use2D, RegWriteD, wb_valid, squash_valid;
  logic        StallD, pc_write_pending, err_underflow;
  logic [15:0] busy;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model: plain in-flight write counts per register
  int cnt [16];
  bit err_m;
  int nxt [16];
  bit err_nxt;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk              (clk),
    .reset            (reset),
    .issue_valid      (issue_valid),
    .issue_ready      (issue_ready),
    .RA1D             (RA1D),
    .RA2D             (RA2D),
    .use1D            (use1D),
    .use2D            (use2D),
    .WA3D             (WA3D),
    .RegWriteD        (RegWriteD),
    .wb_valid         (wb_valid),
    .WA3W             (WA3W),
    .squash_valid     (squash_valid),
    .squash_wa3       (squash_wa3),
    .StallD           (StallD),
    .busy             (busy),
    .pc_write_pending (pc_write_pending),
    .err_underflow    (err_underflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 16; r++) cnt[r] = 0;
    err_m = 0;
  endtask

  task automatic idle();
    issue_valid = 0; use1D = 0; use2D = 0; RegWriteD = 0;
    RA1D = 0; RA2D = 0; WA3D = 0;
    wb_valid = 0; WA3W = 0; squash_valid = 0; squash_wa3 = 0;
  endtask

  // Compare DUT against the model and work out the model's next state.
  task automatic compare_model();
    bit hz, acc;
    int d [16];
    logic [15:0] eb;
    hz = (use1D && cnt[RA1D] != 0) || (use2D && cnt[RA2D] != 0) ||
         (RegWriteD && cnt[WA3D] == MAXC);
    eb = '0;
    for (int r = 0; r < 16; r++) eb[r] = (cnt[r] != 0);
    chk("issue_ready", issue_ready, !hz);
    chk("StallD", StallD, issue_valid && hz);
    chk("busy", busy, eb);
`ifdef SCOREBOARD_PC_TRACK_EN
    chk("pc_write_pending", pc_write_pending, cnt[15] != 0);
`else
    chk("pc_write_pending", pc_write_pending, 0);
`endif
    chk("err_underflow", err_underflow, err_m);
    acc = issue_valid && !hz && RegWriteD;
    for (int r = 0; r < 16; r++) d[r] = 0;
    if (acc) d[WA3D] += 1;
    if (wb_valid) d[WA3W] -= 1;
    if (squash_valid) d[squash_wa3] -= 1;
`ifndef SCOREBOARD_PC_TRACK_EN
    d[15] = 0;
`endif
    err_nxt = err_m;
    for (int r = 0; r < 16; r++) begin
      nxt[r] = cnt[r] + d[r];
      if (nxt[r] < 0) begin
        nxt[r] = 0;
        err_nxt = 1;
      end
    end
  endtask

  // Inputs are set just after a falling edge; this checks and advances a cycle.
  task automatic tick();
    #1;
    compare_model();
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < 16; r++) cnt[r] = nxt[r];
      err_m = err_nxt;
    end
    @(negedge clk);
  endtask

  task automatic issue_w(input logic [3:0] wa);
    idle();
    issue_valid = 1; RegWriteD = 1; WA3D = wa;
  endtask

  function automatic logic [3:0] rreg();
    if ($urandom_range(0, 1) == 0) return 4'($urandom_range(0, 3));
    return 4'($urandom_range(0, 15));
  endfunction

  // Pick a register with a pending write (model view); ok=0 if none.
  task automatic pick_busy(output logic [3:0] r, output bit ok);
    int s;
    s = $urandom_range(0, 15);
    ok = 0; r = 0;
    for (int k = 0; k < 16; k++) begin
      if (!ok && cnt[(s + k) % 16] != 0) begin
        r = 4'((s + k) % 16);
        ok = 1;
      end
    end
  endtask

  task automatic rand_cycle(input bit guided);
    bit ok;
    logic [3:0] r;
    issue_valid = 1'($urandom_range(0, 1));
    RA1D = rreg(); RA2D = rreg(); WA3D = rreg();
    use1D = 1'($urandom_range(0, 1));
    use2D = 1'($urandom_range(0, 1));
    RegWriteD = ($urandom_range(0, 3) != 0);
    if (guided) begin
      pick_busy(r, ok);
      wb_valid = ok && ($urandom_range(0, 2) != 0); WA3W = r;
      pick_busy(r, ok);
      squash_valid = ok && ($urandom_range(0, 4) == 0); squash_wa3 = r;
    end else begin
      wb_valid = 1'($urandom_range(0, 1)); WA3W = rreg();
      squash_valid = ($urandom_range(0, 3) == 0); squash_wa3 = rreg();
    end
    tick();
  endtask

  initial begin
    idle();
    model_clear();
    reset = 0;
    // inputs active while reset is low must be ignored
    issue_valid = 1; RegWriteD = 1; WA3D = 4'd6; wb_valid = 1; WA3W = 4'd1;
    #3;
    chk("rst_busy", busy, 16'h0000);
    chk("rst_ready", issue_ready, 1);
    chk("rst_err", err_underflow, 0);
    @(negedge clk); tick(); tick();
    idle();
    reset = 1;
    tick();
    chk("rst_busy6_after", busy[6], 0);

    // RAW hazard, released one cycle after write-back
    issue_w(4'd3); tick();
    idle(); issue_valid = 1; RA1D = 4'd3; use1D = 1;
    #1;
    chk("raw_stall", StallD, 1);
    chk("raw_ready", issue_ready, 0);
    tick();
    wb_valid = 1; WA3W = 4'd3;
    #1;
    chk("raw_no_bypass", StallD, 1);
    tick();
    wb_valid = 0;
    #1;
    chk("raw_released", StallD, 0);
    tick();

    // counter saturation on register 5
    for (int i = 0; i < 3; i++) begin issue_w(4'd5); tick(); end
    issue_w(4'd5);
    #1;
    chk("sat_ready", issue_ready, 0);
    tick();
    wb_valid = 1; WA3W = 4'd5;
    tick();
    wb_valid = 0;
    #1;
    chk("sat_ready_after_wb", issue_ready, 1);
    tick();

    // issue and write-back to the same register cancel out
    issue_w(4'd7); tick();
    issue_w(4'd7); wb_valid = 1; WA3W = 4'd7; tick();
    idle();
    #1;
    chk("same_cycle_busy7", busy[7], 1);
    wb_valid = 1; WA3W = 4'd7; tick();
    idle();
    #1;
    chk("same_cycle_cnt_was_1", busy[7], 0);
    tick();

    // register 15 / PC tracking
    issue_w(4'd15); tick();
    idle();
    #1;
`ifdef SCOREBOARD_PC_TRACK_EN
    chk("pc_pending", pc_write_pending, 1);
    chk("pc_busy15", busy[15], 1);
`else
    chk("pc_pending", pc_write_pending, 0);
    chk("pc_busy15", busy[15], 0);
`endif
    wb_valid = 1; WA3W = 4'd15; tick();
    idle(); tick();
    chk("pc_no_err", err_underflow, 0);

    for (int i = 0; i < 300; i++) rand_cycle(1);

    // underflow on an idle register is clamped and sticky
    idle(); tick();
    for (int i = 0; i < 8; i++) begin
      if (busy[9]) begin wb_valid = 1; WA3W = 4'd9; end
      else idle();
      tick();
    end
    idle(); wb_valid = 1; WA3W = 4'd9; tick();
    idle();
    #1;
    chk("uflow_err", err_underflow, 1);
    chk("uflow_busy9", busy[9], 0);
    tick(); tick();
    chk("uflow_sticky", err_underflow, 1);

    for (int i = 0; i < 200; i++) rand_cycle(0);

    // asynchronous reset mid-stream with counts [2]=2, [4]=1
    for (int r = 0; r < 16; r++) begin
      while (busy[r]) begin idle(); wb_valid = 1; WA3W = 4'(r); tick(); end
    end
    issue_w(4'd2); tick();
    issue_w(4'd2); tick();
    issue_w(4'd4); tick();
    idle(); issue_valid = 1; RA1D = 4'd2; use1D = 1;
    #1;
    chk("pre_rst_stall", StallD, 1);
    #1;
    reset = 0;
    model_clear();
    #1;
    chk("async_busy", busy, 16'h0000);
    chk("async_stall", StallD, 0);
    chk("async_err", err_underflow, 0);
    @(negedge clk);
    tick();
    reset = 1;
    idle();
    tick();

    for (int i = 0; i < 100; i++) rand_cycle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
